// File: rtl/serial_link_pkg.sv
// Shared definitions for the on-chip serial link (PISO transmitter, SIPO receiver).
package serial_link_pkg;

    localparam int unsigned LINK_STATE_W = 2;

    typedef enum logic [LINK_STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } link_state_e;

endpackage

// File: rtl/piso_reg_if.sv
// Load handshake and serial strobe bundle of the PISO transmit register.
interface piso_reg_if #(
    parameter int unsigned INPUT_BW = 8
);

    logic [INPUT_BW-1:0] din_bus_i;
    logic                load_i;
    logic                load_ready_o;
    logic                serial_data_o;
    logic                serial_valid_o;
    logic                busy_o;
    logic                frame_done_o;

    modport master (
        output din_bus_i,
        output load_i,
        input  load_ready_o,
        input  serial_data_o,
        input  serial_valid_o,
        input  busy_o,
        input  frame_done_o
    );

    modport slave (
        input  din_bus_i,
        input  load_i,
        output load_ready_o,
        output serial_data_o,
        output serial_valid_o,
        output busy_o,
        output frame_done_o
    );

endinterface

// File: rtl/piso_reg.sv
// Parallel-in serial-out transmitter: MSB-first strobed bits, optional trailing
// flush strobe, and a one-word holding buffer for gapless back-to-back frames.
module piso_reg
    import serial_link_pkg::*;
#(
    parameter int unsigned INPUT_BW    = 8,
    parameter int unsigned TRAIL_FLUSH = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    piso_reg_if.slave  bus
);

    localparam int unsigned           CNT_W    = $clog2(INPUT_BW);
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(INPUT_BW - 1);

    link_state_e          state_q, state_d;
    logic [INPUT_BW-1:0]  shift_q, shift_d;
    logic [INPUT_BW-1:0]  hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 serial_data_q, serial_data_d;
    logic                 serial_valid_q, serial_valid_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;

    logic                 load_acc;
    logic                 last_strobe;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            hold_q         <= '0;
            hold_valid_q   <= 1'b0;
            cnt_q          <= '0;
            serial_data_q  <= 1'b0;
            serial_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            hold_q         <= hold_d;
            hold_valid_q   <= hold_valid_d;
            cnt_q          <= cnt_d;
            serial_data_q  <= serial_data_d;
            serial_valid_q <= serial_valid_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // Next-state, load routing and next output values
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        cnt_d        = cnt_q;

        load_acc    = bus.load_i && !hold_valid_q;
        last_strobe = (state_q == FLUSH) ||
                      ((state_q == SHIFT) && (cnt_q == LAST_BIT) && (TRAIL_FLUSH == 0));

        case (state_q)
            IDLE: begin
                if (load_acc) begin
                    state_d = SHIFT;
                    shift_d = bus.din_bus_i;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                shift_d = {shift_q[INPUT_BW-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                if ((cnt_q == LAST_BIT) && (TRAIL_FLUSH != 0)) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                state_d = FLUSH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A word arriving mid-frame parks in the holding register
        if (load_acc && (state_q != IDLE) && !last_strobe) begin
            hold_d       = bus.din_bus_i;
            hold_valid_d = 1'b1;
        end

        // End of frame: held word first, then a same-cycle load, else go idle
        if (last_strobe) begin
            cnt_d = '0;
            if (hold_valid_q) begin
                state_d      = SHIFT;
                shift_d      = hold_q;
                hold_valid_d = 1'b0;
            end else if (load_acc) begin
                state_d = SHIFT;
                shift_d = bus.din_bus_i;
            end else begin
                state_d = IDLE;
            end
        end

        serial_valid_d = (state_d != IDLE);
        busy_d         = (state_d != IDLE);
        serial_data_d  = (state_d == SHIFT) && shift_d[INPUT_BW-1];
        frame_done_d   = (state_d == FLUSH) ||
                         ((state_d == SHIFT) && (cnt_d == LAST_BIT) && (TRAIL_FLUSH == 0));
    end

    assign bus.load_ready_o   = !hold_valid_q;
    assign bus.serial_data_o  = serial_data_q;
    assign bus.serial_valid_o = serial_valid_q;
    assign bus.busy_o         = busy_q;
    assign bus.frame_done_o   = frame_done_q;

endmodule

// File: tb/tb_piso_reg.sv
// Bench for piso_reg: flush (TF=1) and no-flush (TF=0) instances share stimulus;
// a strobe-stream model predicts every output each cycle.
module tb_piso_reg;

    localparam int unsigned BW = 8;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [BW-1:0] din;
    logic          load;
    logic          chk_en = 1'b0;
    int            n_chk  = 0;
    int            n_fail = 0;

    // Per instance (index = TRAIL_FLUSH): future strobes {done,data}, accepted words
    logic [1:0]    mq [2][$];
    logic [BW-1:0] wq [2][$];
    logic [BW-1:0] rx [2];
    logic          acc_m;

    always #5 clk_i = ~clk_i;

    piso_reg_if #(.INPUT_BW(BW)) bus1 ();
    piso_reg_if #(.INPUT_BW(BW)) bus0 ();

    assign bus1.din_bus_i = din;
    assign bus1.load_i    = load;
    assign bus0.din_bus_i = din;
    assign bus0.load_i    = load;

    piso_reg #(.INPUT_BW(BW), .TRAIL_FLUSH(1)) dut1 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus1)
    );

    piso_reg #(.INPUT_BW(BW), .TRAIL_FLUSH(0)) dut0 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus0)
    );

    function automatic int flen(input int tf);
        return BW + tf;
    endfunction

    task automatic chk(input string nm, input int d, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s tf%0d @%0t: got %h required %h", nm, d, $time, act, exp);
        end
    endtask

    // Model: a word accepted while at most one frame's strobes remain is queued behind them
    always @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            if (reset_i) begin
                mq[i].delete();
                wq[i].delete();
            end else begin
                acc_m = load && (mq[i].size() <= flen(i));
                if (mq[i].size() > 0) void'(mq[i].pop_front());
                if (acc_m) begin
                    wq[i].push_back(din);
                    for (int b = 0; b < int'(BW); b++)
                        mq[i].push_back({(i == 0) && (b == int'(BW) - 1), din[BW-1-b]});
                    if (i == 1) mq[i].push_back(2'b10);
                end
            end
        end
    end

    // Compare every output against the model; a receiver rebuilds each word at frame end
    logic av, ad, adn, ab, ar, ev, ed, edn;
    logic [BW-1:0] ew;
    always @(negedge clk_i) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                av  = (i == 1) ? bus1.serial_valid_o : bus0.serial_valid_o;
                ad  = (i == 1) ? bus1.serial_data_o  : bus0.serial_data_o;
                adn = (i == 1) ? bus1.frame_done_o   : bus0.frame_done_o;
                ab  = (i == 1) ? bus1.busy_o         : bus0.busy_o;
                ar  = (i == 1) ? bus1.load_ready_o   : bus0.load_ready_o;
                ev  = (mq[i].size() > 0);
                ed  = ev ? mq[i][0][0] : 1'b0;
                edn = ev ? mq[i][0][1] : 1'b0;
                chk("serial_valid", i, BW'(av),  BW'(ev));
                chk("serial_data",  i, BW'(ad),  BW'(ed));
                chk("frame_done",   i, BW'(adn), BW'(edn));
                chk("busy",         i, BW'(ab),  BW'(ev));
                chk("load_ready",   i, BW'(ar),  BW'(mq[i].size() <= flen(i)));
                if (av === 1'b1) begin
                    if (!(i == 1 && adn === 1'b1)) rx[i] = {rx[i][BW-2:0], ad};
                    if (adn === 1'b1) begin
                        ew = (wq[i].size() > 0) ? wq[i].pop_front() : ~rx[i];
                        chk("rx_word", i, rx[i], ew);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    int            nv;
    logic [BW-1:0] cap;

    initial begin
        reset_i = 1'b1;
        load    = 1'b0;
        din     = '0;
        cyc();
        chk_en = 1'b1;

        // Reset held with random load/din: outputs quiet, ready high
        for (int k = 0; k < 4; k++) begin
            load = 1'($urandom_range(0, 1));
            din  = BW'($urandom);
            @(negedge clk_i);
            chk("rst_valid", 1, BW'(bus1.serial_valid_o), 8'h00);
            chk("rst_ready", 1, BW'(bus1.load_ready_o),   8'h01);
            chk("rst_busy",  0, BW'(bus0.busy_o),         8'h00);
            cyc();
        end
        load    = 1'b0;
        reset_i = 1'b0;
        for (int k = 0; k < 3; k++) cyc();

        // Single word A5 from idle
        load = 1'b1;
        din  = 8'hA5;
        cap  = '0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            load = 1'b0;
            din  = BW'($urandom);
            @(negedge clk_i);
            if (k <= 8) cap = {cap[BW-2:0], bus1.serial_data_o};
            if (k == 8) begin
                chk("a5_done_early", 1, BW'(bus1.frame_done_o), 8'h00);
                chk("tf0_done_c8",   0, BW'(bus0.frame_done_o), 8'h01);
            end
            if (k == 9) begin
                chk("a5_flush_valid", 1, BW'(bus1.serial_valid_o), 8'h01);
                chk("a5_flush_data",  1, BW'(bus1.serial_data_o),  8'h00);
                chk("a5_flush_done",  1, BW'(bus1.frame_done_o),   8'h01);
                chk("tf0_idle_c9",    0, BW'(bus0.busy_o),         8'h00);
            end
        end
        chk("a5_word", 1, cap, 8'hA5);

        // Back-to-back 3C then C3
        load = 1'b1;
        din  = 8'h3C;
        nv   = 0;
        for (int k = 1; k <= 22; k++) begin
            cyc();
            load = (k == 1);
            din  = (k == 1) ? 8'hC3 : 8'h00;
            @(negedge clk_i);
            if (k <= 18 && bus1.serial_valid_o === 1'b1) nv++;
            if (k == 2)  chk("b2b_ready_c2",  1, BW'(bus1.load_ready_o),   8'h00);
            if (k == 9)  chk("b2b_ready_c9",  1, BW'(bus1.load_ready_o),   8'h00);
            if (k == 10) chk("b2b_ready_c10", 1, BW'(bus1.load_ready_o),   8'h01);
            if (k == 19) chk("b2b_valid_c19", 1, BW'(bus1.serial_valid_o), 8'h00);
        end
        chk("b2b_strobes", 1, BW'(nv), 8'd18);

        // Load on the last strobe with hold empty
        load = 1'b1;
        din  = 8'h5A;
        for (int k = 1; k <= 22; k++) begin
            cyc();
            load = (k == 9);
            din  = (k == 9) ? 8'h96 : 8'h00;
            @(negedge clk_i);
            if (k == 9)  chk("last_done",   1, BW'(bus1.frame_done_o),   8'h01);
            if (k == 10) begin
                chk("last_next_valid", 1, BW'(bus1.serial_valid_o), 8'h01);
                chk("last_next_msb",   1, BW'(bus1.serial_data_o),  8'h01);
                chk("last_next_ready", 1, BW'(bus1.load_ready_o),   8'h01);
            end
            if (k == 11) chk("last_next_bit1", 1, BW'(bus1.serial_data_o), 8'h00);
        end

        // FF on the no-flush instance
        load = 1'b1;
        din  = 8'hFF;
        nv   = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            load = 1'b0;
            @(negedge clk_i);
            if (k <= 8 && bus0.serial_valid_o === 1'b1 && bus0.serial_data_o === 1'b1) nv++;
            if (k == 8) chk("ff_done_c8",  0, BW'(bus0.frame_done_o),   8'h01);
            if (k == 9) begin
                chk("ff_busy_c9",  0, BW'(bus0.busy_o),         8'h00);
                chk("ff_valid_c9", 0, BW'(bus0.serial_valid_o), 8'h00);
            end
        end
        chk("ff_ones", 0, BW'(nv), 8'd8);

        // Reset mid-frame with a held word
        load = 1'b1;
        din  = 8'h81;
        nv   = 0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            load    = (k == 1);
            din     = (k == 1) ? 8'h7E : 8'h00;
            reset_i = (k == 4);
            @(negedge clk_i);
            if (k == 4) chk("mid_valid_c4", 1, BW'(bus1.serial_valid_o), 8'h01);
            if (k == 5) begin
                chk("mid_valid_c5", 1, BW'(bus1.serial_valid_o), 8'h00);
                chk("mid_ready_c5", 1, BW'(bus1.load_ready_o),   8'h01);
            end
            if (k >= 5 && (bus1.serial_valid_o === 1'b1 || bus0.serial_valid_o === 1'b1)) nv++;
        end
        chk("mid_no_strobes", 1, BW'(nv), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
